sram6t_bank: RTL and testbench

SRAM6T_BANK -- requirements
Module: sram6t_bank

---
 rtl/sram6t_pkg.sv | 19 +
 rtl/sram6t_cell_array.sv | 46 ++++
 rtl/sram6t_bank.sv | 136 +++++++++++++
 tb/tb_sram6t_bank.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram6t_pkg.sv
// rtl/sram6t_pkg.sv - shared types and default geometry for the 6T SRAM bank
//
// Purpose: FSM state encoding and default parameter values used by
//          sram6t_bank and sram6t_cell_array.
// Ports:   none (package).

package sram6t_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRECHARGE = 2'd1,
    ACCESS    = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_PRE_CYC = 1;

endpackage

// File: rtl/sram6t_cell_array.sv
// rtl/sram6t_cell_array.sv - DATA_W x DEPTH storage selected by one-hot wordline
//
// Purpose: behavioural cell array. One synchronous write port and one
//          combinational read port, both selected by the one-hot wordline.
//          No reset: contents survive bank reset.
// Ports:
//   clk    in   clock, write on rising edge
//   wl     in   DEPTH one-hot wordline (all-zero = no row selected)
//   we     in   write enable for the selected row
//   wdata  in   DATA_W write data
//   rdata  out  DATA_W data of the selected row (zero when no row selected)

module sram6t_cell_array
  import sram6t_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 2 ** DEF_ADDR_W
) (
  input  logic              clk,
  input  logic [DEPTH-1:0]  wl,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (we && wl[i]) begin
        mem[i] <= wdata;
      end
    end
  end

  // Wired-OR of the selected row, as the shared bitlines would see it.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wl[i]) begin
        rdata = rdata | mem[i];
      end
    end
  end

endmodule

// File: rtl/sram6t_bank.sv
// rtl/sram6t_bank.sv - single-port 6T SRAM bank with precharge/access sequencing
//
// Purpose: accepts one request at a time, precharges for PRE_CYC cycles,
//          fires the wordline for one ACCESS cycle, then writes the array or
//          registers the read data with a one-cycle rsp_valid pulse.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request offered
//   req_ready  out  high only in IDLE
//   req_we     in   1 = write, 0 = read
//   req_addr   in   ADDR_W word address
//   req_wdata  in   DATA_W write data
//   rsp_valid  out  one-cycle read-data pulse
//   rsp_rdata  out  DATA_W read data, held until the next read completes
//   wl         out  DEPTH one-hot wordline, high only in ACCESS
//   pre_n      out  precharge strobe, low during PRECHARGE

module sram6t_bank
  import sram6t_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PRE_CYC = DEF_PRE_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [2**ADDR_W-1:0]  wl,
  output logic                  pre_n
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (PRE_CYC > 1) ? $clog2(PRE_CYC) : 1;

  if (PRE_CYC < 1) begin : g_bad_pre_cyc
    $error("sram6t_bank: PRE_CYC must be at least 1");
  end

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    pre_cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                accept;
  logic                pre_done;
  logic                arr_we;
  logic [DATA_W-1:0]   arr_rdata;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign pre_done  = (pre_cnt == CNT_W'(PRE_CYC - 1));
  assign arr_we    = (state == ACCESS) & we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wl        = '0;
    pre_n     = 1'b1;
    case (state)
      IDLE: begin
        if (accept) state_nxt = PRECHARGE;
      end
      PRECHARGE: begin
        pre_n = 1'b0;
        if (pre_done) state_nxt = ACCESS;
      end
      ACCESS: begin
        wl[addr_q] = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counts cycles spent in PRECHARGE; cleared whenever we are elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (state == PRECHARGE) begin
      pre_cnt <= pre_cnt + 1'b1;
    end else begin
      pre_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Read data is registered at the edge ending ACCESS; writes leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= (state == ACCESS) && !we_q;
      if ((state == ACCESS) && !we_q) begin
        rsp_rdata <= arr_rdata;
      end
    end
  end

  sram6t_cell_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .wl    (wl),
    .we    (arr_we),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_sram6t_bank.sv
// tb/tb_sram6t_bank.sv - scoreboard bench for sram6t_bank

module tb_sram6t_bank;
  import sram6t_pkg::*;

  localparam int DW = DEF_DATA_W, AW = DEF_ADDR_W, PC = DEF_PRE_CYC, DEPTH = 1 << AW;
  localparam int BDW = 8, BAW = 4, BPC = 3, BDEPTH = 1 << BAW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h cycle=%0d", name, got, want, cyc);
    end
  endtask

  // ---------------- DUT A: default geometry ----------------
  logic              req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0;
  logic              req_ready, rsp_valid, pre_n;
  logic [DW-1:0]     rsp_rdata;
  logic [DEPTH-1:0]  wl;

  sram6t_bank u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wl(wl), .pre_n(pre_n)
  );

  // ---------------- DUT B: PRE_CYC=3, 8-bit, 16 words ----------------
  logic              b_req_valid = 1'b0, b_req_we = 1'b0;
  logic [BAW-1:0]    b_req_addr = '0;
  logic [BDW-1:0]    b_req_wdata = '0;
  logic              b_req_ready, b_rsp_valid, b_pre_n;
  logic [BDW-1:0]    b_rsp_rdata;
  logic [BDEPTH-1:0] b_wl;

  sram6t_bank #(.DATA_W(BDW), .ADDR_W(BAW), .PRE_CYC(BPC)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .wl(b_wl), .pre_n(b_pre_n)
  );

  // ---------------- reference model A ----------------
  // An access accepted in cycle k precharges in k+1..k+PC, drives its
  // wordline in k+PC+1 and (for reads) responds in k+PC+2, when the bank is
  // ready again.
  typedef struct { int due; logic [DW-1:0] data; } exp_t;
  exp_t q[$];
  logic [DW-1:0] mem_m [DEPTH];
  bit act_v = 0, act_we = 0;
  int act_acc = 0, act_addr = 0, busy_until = 0;
  logic [DW-1:0] act_data;
  logic [DEPTH-1:0] ewl;
  bit epre;

  always @(negedge clk) begin
    if (!rst_n) begin
      act_v = 0;
      busy_until = cyc;
      q.delete();
      chk("rst_wl", 32'(wl), 0);
      chk("rst_pre_n", 32'(pre_n), 1);
    end else begin
      ewl = '0;
      epre = 1;
      if (act_v && cyc == act_acc + PC + 1) ewl[act_addr] = 1'b1;
      if (act_v && cyc > act_acc && cyc <= act_acc + PC) epre = 0;
      chk("wl", 32'(wl), 32'(ewl));
      chk("pre_n", 32'(pre_n), 32'(epre));
      chk("req_ready", 32'(req_ready), 32'(cyc >= busy_until));
      if (act_v && cyc == act_acc + PC + 1) begin
        if (act_we) mem_m[act_addr] = act_data;
        else q.push_back('{due: cyc + 1, data: mem_m[act_addr]});
        act_v = 0;
      end
      if (req_valid && cyc >= busy_until) begin
        act_v = 1; act_acc = cyc; act_we = req_we;
        act_addr = int'(req_addr); act_data = req_wdata;
        busy_until = cyc + PC + 2;
      end
    end
  end

  // ---------------- response monitor A ----------------
  logic [DW-1:0] held = '0;
  bit due;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    end else begin
      due = (q.size() > 0) && (q[0].due == cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(due));
      if (due) begin
        e = q.pop_front();
        held = e.data;
      end
      chk("rsp_rdata", 32'(rsp_rdata), 32'(held));
    end
  end

  // ---------------- reference model + monitor B ----------------
  typedef struct { int due; logic [BDW-1:0] data; } bexp_t;
  bexp_t bq[$];
  logic [BDW-1:0] b_mem [BDEPTH];
  bit b_act_v = 0, b_act_we = 0;
  int b_act_acc = 0, b_act_addr = 0, b_busy = 0;
  logic [BDW-1:0] b_act_data, b_held = '0;
  logic [BDEPTH-1:0] b_ewl;
  bit b_epre, b_due;
  bexp_t be;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_act_v = 0;
      b_busy = cyc;
      bq.delete();
      b_held = '0;
      chk("b_rst_rsp_valid", 32'(b_rsp_valid), 0);
    end else begin
      b_ewl = '0;
      b_epre = 1;
      if (b_act_v && cyc == b_act_acc + BPC + 1) b_ewl[b_act_addr] = 1'b1;
      if (b_act_v && cyc > b_act_acc && cyc <= b_act_acc + BPC) b_epre = 0;
      chk("b_wl", 32'(b_wl), 32'(b_ewl));
      chk("b_pre_n", 32'(b_pre_n), 32'(b_epre));
      chk("b_req_ready", 32'(b_req_ready), 32'(cyc >= b_busy));
      b_due = (bq.size() > 0) && (bq[0].due == cyc);
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(b_due));
      if (b_due) begin
        be = bq.pop_front();
        b_held = be.data;
      end
      chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(b_held));
      if (b_act_v && cyc == b_act_acc + BPC + 1) begin
        if (b_act_we) b_mem[b_act_addr] = b_act_data;
        else bq.push_back('{due: cyc + 1, data: b_mem[b_act_addr]});
        b_act_v = 0;
      end
      if (b_req_valid && cyc >= b_busy) begin
        b_act_v = 1; b_act_acc = cyc; b_act_we = b_req_we;
        b_act_addr = int'(b_req_addr); b_act_data = b_req_wdata;
        b_busy = cyc + BPC + 2;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
    end
  endtask

  // Offers a request until accepted, then scrambles the request fields so
  // any late sampling of them would corrupt the access.
  task automatic issue(input bit we, input int addr, input int data);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_addr = AW'(addr); req_wdata = DW'(data);
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
  endtask

  task automatic b_issue(input bit we, input int addr, input int data);
    int n = 0;
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = BAW'(addr); b_req_wdata = BDW'(data);
    do begin @(negedge clk); n++; end while (!b_req_ready && n < 20);
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    b_req_addr = BAW'($urandom); b_req_wdata = BDW'($urandom);
  endtask

  bit b_done = 0;
  initial begin
    @(posedge rst_n);
    @(posedge clk); #1;
    b_issue(1, 15, 8'h5C);
    b_issue(0, 15, 0);
    b_issue(1, 0, 8'hA7);
    b_issue(0, 0, 0);
    b_issue(0, 15, 0);
    repeat (8) @(posedge clk);
    b_done = 1;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    // write then read back the same word
    issue(1, 2, 4'hA);
    issue(0, 2, 0);
    idle(2);
    // walking-one pattern across every word, then read back in order
    for (int i = 0; i < DEPTH; i++) issue(1, i, 1 << i);
    for (int i = 0; i < DEPTH; i++) issue(0, i, 0);
    idle(1);
    // back-to-back reads with valid held high
    for (int i = 0; i < 6; i++) issue(0, i % DEPTH, 0);
    idle(2);
    // reset during precharge must abort the pending write
    issue(1, 1, 4'h3);
    idle(3);
    issue(1, 1, 4'hF);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    issue(0, 1, 0);
    idle(2);
    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      else issue(1'($urandom), $urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
    end
    idle(6);
    wait (b_done);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    chk("b_scoreboard_drained", 32'(bq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
